// File: rtl/pivota_order_executor_if.sv
// pivota_order_executor_if: order and fill channels of the order executor.
//   Order channel : ord_valid/ord_ready handshake carrying ord_type, ord_qty.
//                   price is the live market price and is sampled at execution.
//   Fill channel  : fill_valid/fill_ready handshake carrying fill_status,
//                   fill_type, fill_qty.
//   master = order source / report consumer, slave = executor.
interface pivota_order_executor_if;
    logic        ord_valid;
    logic        ord_ready;
    logic [3:0]  ord_type;
    logic [3:0]  ord_qty;
    logic [31:0] price;
    logic        fill_valid;
    logic        fill_ready;
    logic [1:0]  fill_status;
    logic [3:0]  fill_type;
    logic [3:0]  fill_qty;

    modport master (
        output ord_valid, ord_type, ord_qty, price, fill_ready,
        input  ord_ready, fill_valid, fill_status, fill_type, fill_qty
    );

    modport slave (
        input  ord_valid, ord_type, ord_qty, price, fill_ready,
        output ord_ready, fill_valid, fill_status, fill_type, fill_qty
    );
endinterface

// File: rtl/pivota_order_executor.sv
// pivota_order_executor: buffers BUY/SELL orders in a FIFO and executes them
// one at a time against a cash balance and a signed position, reporting each
// outcome on the fill channel.
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-high reset
//   bus        : order/fill channels (slave modport)
//   position   : signed net holding
//   cash       : unsigned balance, INIT_CASH after reset
//   fill_cnt   : lifetime fills (saturating)
//   reject_cnt : lifetime rejects (saturating)
// Build option: define PIVOTA_SHORT_SELL_EN to allow SELL below zero position
// (down to -32768); undefined, a SELL larger than the position is rejected.
module pivota_order_executor #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] INIT_CASH  = 32'd1000
) (
    input  logic                     clk,
    input  logic                     rst,
    pivota_order_executor_if.slave   bus,
    output logic signed [15:0]       position,
    output logic [31:0]              cash,
    output logic [15:0]              fill_cnt,
    output logic [15:0]              reject_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_REPORT} state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            ready_q;
    logic            push;
    logic            pop;

    logic [3:0]      op_type;
    logic [3:0]      op_qty;
    logic            fill_valid_q;
    logic [1:0]      fill_status_q;
    logic [3:0]      fill_type_q;
    logic [3:0]      fill_qty_q;

    logic [35:0]         cost;
    logic [36:0]         cash_sum;
    logic signed [17:0]  pos_ext;
    logic signed [17:0]  qty_ext;
    logic signed [17:0]  buy_pos;
    logic signed [17:0]  sell_pos;
    logic [1:0]          exec_status;
    logic signed [15:0]  pos_n;
    logic [31:0]         cash_n;

    assign bus.ord_ready   = ready_q;
    assign bus.fill_valid  = fill_valid_q;
    assign bus.fill_status = fill_status_q;
    assign bus.fill_type   = fill_type_q;
    assign bus.fill_qty    = fill_qty_q;

    assign push = bus.ord_valid & ready_q;
    assign pop  = (state == S_IDLE) && (count != '0);

    // Occupancy after this cycle's push/pop; simultaneous push+pop cancel.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // FIFO pointers and registered not-full flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count   <= count_next;
            ready_q <= (count_next != CW'(FIFO_DEPTH));
        end
    end

    // FIFO storage: {type, qty}; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.ord_type, bus.ord_qty};
    end

    // Execution rules for the order held in the operand registers.
    always_comb begin
        cost        = 36'(bus.price) * 36'(op_qty);
        cash_sum    = 37'(cash) + 37'(cost);
        pos_ext     = 18'(position);
        qty_ext     = {14'b0, op_qty};
        buy_pos     = pos_ext + qty_ext;
        sell_pos    = pos_ext - qty_ext;
        exec_status = 2'd0;
        pos_n       = position;
        cash_n      = cash;
        case (op_type)
            4'd1: begin
                if (cost > 36'(cash)) begin
                    exec_status = 2'd1;
                end else if (buy_pos > 18'sd32767) begin
                    exec_status = 2'd2;
                end else begin
                    cash_n = cash - 32'(cost);
                    pos_n  = 16'(buy_pos);
                end
            end
            4'd2: begin
`ifdef PIVOTA_SHORT_SELL_EN
                if (sell_pos < -18'sd32768) begin
`else
                if (sell_pos < 18'sd0) begin
`endif
                    exec_status = 2'd2;
                end else begin
                    pos_n  = 16'(sell_pos);
                    cash_n = (cash_sum > 37'h0_FFFF_FFFF) ? '1 : 32'(cash_sum);
                end
            end
            default: exec_status = 2'd3;
        endcase
    end

    // Control FSM: IDLE pops an order, EXEC applies it, REPORT holds the fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            op_type       <= '0;
            op_qty        <= '0;
            fill_valid_q  <= 1'b0;
            fill_status_q <= '0;
            fill_type_q   <= '0;
            fill_qty_q    <= '0;
            position      <= '0;
            cash          <= INIT_CASH;
            fill_cnt      <= '0;
            reject_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {op_type, op_qty} <= mem[rd_ptr];
                        state             <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    fill_status_q <= exec_status;
                    fill_type_q   <= op_type;
                    fill_qty_q    <= op_qty;
                    position      <= pos_n;
                    cash          <= cash_n;
                    if (exec_status == 2'd0) begin
                        if (fill_cnt != 16'hFFFF) fill_cnt <= fill_cnt + 16'd1;
                    end else begin
                        if (reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 16'd1;
                    end
                    fill_valid_q <= 1'b1;
                    state        <= S_REPORT;
                end
                S_REPORT: begin
                    if (bus.fill_ready) begin
                        fill_valid_q <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
